// File: rtl/cpu_stack_if.sv
// cpu_stack_if: command/status bundle for one cpu_stack_unit instance.
//   master drives : op (3b opcode), din (WIDTH), err_clr
//   slave drives  : tos, nos (WIDTH), depth, hwm (AW+2), ovf, unf, err
interface cpu_stack_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
);
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [AW+1:0]    depth;
    logic [AW+1:0]    hwm;
    logic             ovf;
    logic             unf;
    logic             err;

    modport master (
        output op, din, err_clr,
        input  tos, nos, depth, hwm, ovf, unf, err
    );

    modport slave (
        input  op, din, err_clr,
        output tos, nos, depth, hwm, ovf, unf, err
    );
endinterface

// File: rtl/cpu_stack_unit.sv
// cpu_stack_unit: hardware stack with TOS/NOS cached in flops and deeper
// entries held in a write-first block RAM. Detects overflow/underflow,
// optionally suppresses illegal ops, and tracks a depth high-water mark.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - cpu_stack_if.slave: op/din/err_clr in; tos/nos/depth/hwm/ovf/unf/err out
// Parameters: WIDTH entry width, AW RAM address width (capacity 2^AW + 2),
//   CHECK 1 = suppress illegal ops, 0 = execute them anyway.
module cpu_stack_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 8,
    parameter int CHECK = 1
) (
    input  logic         clk,
    input  logic         rst,
    cpu_stack_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_SWAP    = 3'd4,
        OP_OVER    = 3'd5,
        OP_ROT     = 3'd6,
        OP_BINOP   = 3'd7
    } op_e;

    localparam int            CAP_I = (1 << AW) + 2;
    localparam logic [AW+1:0] CAP   = (AW+2)'(CAP_I);

    op_e              op;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [AW+1:0]    depth_q, depth_d, depth_raw;
    logic [AW+1:0]    hwm_q, hwm_d, hwm_base;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             err_q, err_d;
    logic [AW+1:0]    need;
    logic             space;
    logic             unf_set, ovf_set, exec;
    logic             we;
    logic [AW-1:0]    addr;

    // Third-from-top: RAM read data, registered
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] third_q;

    assign op = op_e'(bus.op);

    always_comb begin
        tos_d     = tos_q;
        nos_d     = nos_q;
        depth_raw = depth_q;
        we        = 1'b0;
        need      = '0;
        space     = 1'b0;

        case (op)
            OP_PUSH:               space = 1'b1;
            OP_POP, OP_REPLACE:    need  = (AW+2)'(1);
            OP_SWAP, OP_BINOP:     need  = (AW+2)'(2);
            OP_OVER: begin
                need  = (AW+2)'(2);
                space = 1'b1;
            end
            OP_ROT:                need  = (AW+2)'(3);
            default: ;
        endcase

        unf_set = (depth_q < need);
        ovf_set = space && (depth_q >= CAP);
        exec    = (CHECK == 0) || !(unf_set || ovf_set);

        if (exec) begin
            case (op)
                OP_PUSH: begin
                    tos_d     = bus.din;
                    nos_d     = tos_q;
                    depth_raw = depth_q + 1'b1;
                    we        = 1'b1;
                end
                OP_POP: begin
                    tos_d     = nos_q;
                    nos_d     = third_q;
                    depth_raw = depth_q - 1'b1;
                end
                OP_REPLACE: tos_d = bus.din;
                OP_SWAP: begin
                    tos_d = nos_q;
                    nos_d = tos_q;
                end
                OP_OVER: begin
                    tos_d     = nos_q;
                    nos_d     = tos_q;
                    depth_raw = depth_q + 1'b1;
                    we        = 1'b1;
                end
                OP_ROT: begin
                    // NOS sinks into the slot third came from
                    tos_d = third_q;
                    nos_d = tos_q;
                    we    = 1'b1;
                end
                OP_BINOP: begin
                    tos_d     = bus.din;
                    nos_d     = third_q;
                    depth_raw = depth_q - 1'b1;
                end
                default: ;
            endcase
        end

        // Unchecked ops wrap modulo 2^(AW+2); never report more than CAP
        depth_d = (depth_raw > CAP) ? CAP : depth_raw;

        // Every write lands at the new stack pointer, which is also where the
        // next third lives, so one address serves both read and write.
        addr = depth_d[AW-1:0] - AW'(2);

        hwm_base = bus.err_clr ? '0 : hwm_q;
        hwm_d    = (depth_d > hwm_base) ? depth_d : hwm_base;
        ovf_d    = (ovf_q & ~bus.err_clr) | ovf_set;
        unf_d    = (unf_q & ~bus.err_clr) | unf_set;
        err_d    = ovf_set | unf_set;
    end

    // Single-port write-first RAM; contents are not reset
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_q[addr] <= nos_q;
            third_q     <= nos_q;
        end else begin
            third_q     <= mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            hwm_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            hwm_q   <= hwm_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    assign bus.tos   = tos_q;
    assign bus.nos   = nos_q;
    assign bus.depth = depth_q;
    assign bus.hwm   = hwm_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
    assign bus.err   = err_q;
endmodule
